// File: rtl/servo_setpoint_sequencer_if.sv
// Target-command channel between a motion planner (master) and servo_setpoint_sequencer (slave).
interface servo_setpoint_sequencer_if;
    // A command transfers on the rising clk edge where cmd_valid && cmd_ready are both high;
    // the master may drop cmd_valid before a transfer, and cmd_pos is ignored while cmd_ready is low.
    logic        cmd_valid;
    logic [11:0] cmd_pos;
    logic        cmd_ready;

    modport master (output cmd_valid, output cmd_pos, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_pos, output cmd_ready);
endinterface

// File: rtl/servo_setpoint_sequencer.sv
// Rate-limited setpoint slewing with settle detection for the servo PID loop.
// Optional settle timeout enabled by defining SEQ_SETTLE_TIMEOUT_EN.
module servo_setpoint_sequencer #(
    parameter int SAMPLE_DIV = 50000,
    parameter int STEP_MAX   = 8,
    parameter int SETTLE_TOL = 4,
    parameter int SETTLE_CNT = 16,
    parameter int HOME_POS   = 2048
`ifdef SEQ_SETTLE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = 2000
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    servo_setpoint_sequencer_if.slave        cmd,
    input  logic                             i_abort,
    input  logic [11:0]                      i_position_fb,
    output logic [11:0]                      o_setpoint,
    output logic                             o_sample_tick,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_settled,
    output logic                             o_timeout,
    output logic [1:0]                       o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int TCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SCW = $clog2(SETTLE_CNT + 1);

    localparam logic [TCW-1:0]     TICK_LAST     = TCW'(SAMPLE_DIV - 1);
    localparam logic [SCW-1:0]     SETTLE_TARGET = SCW'(SETTLE_CNT);
    localparam logic signed [12:0] STEP_L        = 13'(STEP_MAX);
    localparam logic signed [12:0] TOL_L         = 13'(SETTLE_TOL);
    localparam logic [11:0]        HOME_L        = 12'(HOME_POS);

    state_t         r_state;
    state_t         w_state_next;
    logic [TCW-1:0] r_tick_cnt;
    logic           w_tick;
    logic [11:0]    r_target;
    logic [11:0]    r_setpoint;
    logic [SCW-1:0] r_settle_cnt;
    logic [SCW-1:0] w_settle_next;
    logic           w_settle_hit;
    logic           r_settled;
    logic           w_accept;
    logic           w_to_hit;

    logic signed [12:0] w_diff;
    logic signed [12:0] w_dist;
    logic signed [12:0] w_step;
    logic signed [12:0] w_ramp_next;
    logic               w_ramp_hit;
    logic signed [12:0] w_err;
    logic signed [12:0] w_err_abs;
    logic               w_in_tol;

    // Sample-period timebase: free-running, never disturbed by commands.
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TCW'(1);
        end
    end

    // Ramp step: move toward target by at most STEP_MAX; never overshoots.
    assign w_diff      = $signed({1'b0, r_target}) - $signed({1'b0, r_setpoint});
    assign w_dist      = w_diff[12] ? -w_diff : w_diff;
    assign w_step      = (w_dist > STEP_L) ? STEP_L : w_dist;
    assign w_ramp_next = w_diff[12] ? ($signed({1'b0, r_setpoint}) - w_step)
                                    : ($signed({1'b0, r_setpoint}) + w_step);
    assign w_ramp_hit  = (w_ramp_next == $signed({1'b0, r_target}));

    // Settle window is measured against the target, not the setpoint.
    assign w_err         = $signed({1'b0, i_position_fb}) - $signed({1'b0, r_target});
    assign w_err_abs     = w_err[12] ? -w_err : w_err;
    assign w_in_tol      = (w_err_abs <= TOL_L);
    assign w_settle_next = w_in_tol ? (r_settle_cnt + SCW'(1)) : '0;
    assign w_settle_hit  = (w_settle_next == SETTLE_TARGET);

    assign w_accept = (r_state == ST_IDLE) && cmd.cmd_valid;

`ifdef SEQ_SETTLE_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TOW-1:0] TO_TARGET = TOW'(TIMEOUT_TICKS);

    logic [TOW-1:0] r_to_cnt;
    logic [TOW-1:0] w_to_next;
    logic           r_timeout;

    assign w_to_next = r_to_cnt + TOW'(1);
    assign w_to_hit  = (w_to_next == TO_TARGET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_RAMP) begin
                r_to_cnt <= '0;
            end else if ((r_state == ST_SETTLE) && w_tick && !i_abort) begin
                r_to_cnt <= w_to_next;
            end
            // Settling on the same tick takes priority over the timeout.
            r_timeout <= (r_state == ST_SETTLE) && w_tick && !i_abort
                         && !w_settle_hit && w_to_hit;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    w_state_next = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick && w_ramp_hit) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (w_settle_hit) begin
                        w_state_next = ST_DONE;
                    end else if (w_to_hit) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd.cmd_ready = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            ST_IDLE:   cmd.cmd_ready = 1'b1;
            ST_RAMP:   o_busy        = 1'b1;
            ST_SETTLE: o_busy        = 1'b1;
            ST_DONE:   o_done        = 1'b1;
            default:   cmd.cmd_ready = 1'b0;
        endcase
    end

    // Abort suppresses the setpoint update even when a tick coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target     <= HOME_L;
            r_setpoint   <= HOME_L;
            r_settle_cnt <= '0;
            r_settled    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_target <= cmd.cmd_pos;
            end
            if ((r_state == ST_RAMP) && w_tick && !i_abort) begin
                r_setpoint <= w_ramp_next[11:0];
            end
            if (r_state == ST_RAMP) begin
                r_settle_cnt <= '0;
            end else if ((r_state == ST_SETTLE) && w_tick && !i_abort) begin
                r_settle_cnt <= w_settle_next;
            end
            if (w_accept) begin
                r_settled <= 1'b0;
            end else if ((r_state == ST_SETTLE) && (w_state_next == ST_DONE)) begin
                r_settled <= 1'b1;
            end
        end
    end

    assign o_setpoint    = r_setpoint;
    assign o_sample_tick = w_tick;
    assign o_settled     = r_settled;
    assign o_state       = r_state;

endmodule

// File: tb/tb_servo_setpoint_sequencer.sv
// Directed bench for servo_setpoint_sequencer; setpoint steps are checked against a model queue.
// Also covers the SEQ_SETTLE_TIMEOUT_EN build when that macro is defined.
module tb_servo_setpoint_sequencer;
    localparam int SAMPLE_DIV    = 4;
    localparam int STEP_MAX      = 8;
    localparam int SETTLE_TOL    = 4;
    localparam int SETTLE_CNT    = 3;
    localparam int HOME_POS      = 2048;
    localparam int TIMEOUT_TICKS = 5;
    localparam int ST_IDLE       = 0;
    localparam int ST_RAMP       = 1;
    localparam int ST_SETTLE     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_abort = 1'b0;
    logic        fb_track = 1'b1;
    logic [11:0] fb_force = 12'd0;
    logic [11:0] i_position_fb;
    logic [11:0] o_setpoint;
    logic        o_sample_tick;
    logic        o_busy;
    logic        o_done;
    logic        o_settled;
    logic        o_timeout;
    logic [1:0]  o_state;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [11:0] exp_q[$];
    int          model_sp = HOME_POS;
    logic [11:0] last_sp = 12'(HOME_POS);
    bit          mon_en = 1'b0;
    int          ticks;

    servo_setpoint_sequencer_if cmd_if();

    assign i_position_fb = fb_track ? o_setpoint : fb_force;

    servo_setpoint_sequencer #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .STEP_MAX   (STEP_MAX),
        .SETTLE_TOL (SETTLE_TOL),
        .SETTLE_CNT (SETTLE_CNT),
        .HOME_POS   (HOME_POS)
`ifdef SEQ_SETTLE_TIMEOUT_EN
        ,
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cmd_if),
        .i_abort       (i_abort),
        .i_position_fb (i_position_fb),
        .o_setpoint    (o_setpoint),
        .o_sample_tick (o_sample_tick),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_settled     (o_settled),
        .o_timeout     (o_timeout),
        .o_state       (o_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every setpoint change must match the next queued model value.
    always @(negedge clk) begin
        if (mon_en && (o_setpoint !== last_sp)) begin
            if (exp_q.size() == 0) begin
                check("sp_unexpected", 32'(o_setpoint), 32'(last_sp));
            end else begin
                check("sp_step", 32'(o_setpoint), 32'(exp_q.pop_front()));
            end
            last_sp = o_setpoint;
        end
    end

    task automatic push_move(input int target);
        int d;
        while (model_sp != target) begin
            d = target - model_sp;
            if (d > STEP_MAX) d = STEP_MAX;
            if (d < -STEP_MAX) d = -STEP_MAX;
            model_sp += d;
            exp_q.push_back(12'(model_sp));
        end
    endtask

    task automatic send_cmd(input int pos);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos   = 12'(pos);
        push_move(pos);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("accept_busy", 32'(o_busy), 1);
        check("accept_ready", 32'(cmd_if.cmd_ready), 0);
    endtask

    task automatic wait_tick_high();
        int n = 0;
        while (o_sample_tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", 32'(o_sample_tick), 1);
    endtask

    task automatic wait_tick();
        wait_tick_high();
        @(negedge clk);
    endtask

    task automatic wait_done(output int nt);
        int n = 0;
        nt = 0;
        while (o_done !== 1'b1 && n < 400) begin
            if (o_sample_tick && o_busy) nt++;
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(o_done), 1);
        check("done_settled", 32'(o_settled), 1);
        check("done_busy", 32'(o_busy), 0);
        @(negedge clk);
        check("post_done_pulse", 32'(o_done), 0);
        check("post_done_ready", 32'(cmd_if.cmd_ready), 1);
        check("post_done_settled", 32'(o_settled), 1);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_pos   = 12'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        check("rst_setpoint", 32'(o_setpoint), HOME_POS);
        check("rst_ready", 32'(cmd_if.cmd_ready), 1);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_settled", 32'(o_settled), 0);
        check("rst_timeout", 32'(o_timeout), 0);
        check("rst_tick", 32'(o_sample_tick), 0);
        check("rst_state", 32'(o_state), ST_IDLE);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("tick_period", 32'(o_sample_tick), 32'((i % 4) == 3));
        end

        // Downward 8-count move: one ramp tick plus settle ticks.
        send_cmd(2040);
        wait_done(ticks);
        check("m2040_ticks", 32'(ticks), 1 + SETTLE_CNT);
        check("m2040_sp", 32'(o_setpoint), 2040);

        send_cmd(2048);
        wait_done(ticks);
        check("m2048_ticks", 32'(ticks), 1 + SETTLE_CNT);

        // 2048 -> 2056 -> 2064 -> 2068
        send_cmd(2068);
        wait_done(ticks);
        check("m2068_ticks", 32'(ticks), 3 + SETTLE_CNT);
        check("m2068_sp", 32'(o_setpoint), 2068);

        // Zero-distance move with one out-of-tolerance tick, then edge-of-window feedback.
        send_cmd(2068);
        wait_tick();
        check("zd_state", 32'(o_state), ST_SETTLE);
        check("zd_sp", 32'(o_setpoint), 2068);
        wait_tick();
        fb_track = 1'b0;
        fb_force = 12'd2074;
        wait_tick();
        check("oot_state", 32'(o_state), ST_SETTLE);
        check("oot_done", 32'(o_done), 0);
        fb_force = 12'd2064;
        wait_done(ticks);
        fb_track = 1'b1;
        check("oot_recover_ticks", 32'(ticks), SETTLE_CNT);

        send_cmd(2048);
        wait_done(ticks);
        check("m2048b_ticks", 32'(ticks), 3 + SETTLE_CNT);

        // Abort on a ramp tick; a command held during RAMP waits for IDLE.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos   = 12'd2100;
        exp_q.push_back(12'd2056);
        model_sp = 2056;
        @(negedge clk);
        cmd_if.cmd_pos = 12'd2000;
        check("ab_accept_busy", 32'(o_busy), 1);
        check("ab_held_ready", 32'(cmd_if.cmd_ready), 0);
        wait_tick();
        check("ab_sp1", 32'(o_setpoint), 2056);
        check("ab_held_state", 32'(o_state), ST_RAMP);
        wait_tick_high();
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        push_move(2000);
        check("ab_sp_frozen", 32'(o_setpoint), 2056);
        check("ab_state", 32'(o_state), ST_IDLE);
        check("ab_busy", 32'(o_busy), 0);
        check("ab_ready", 32'(cmd_if.cmd_ready), 1);
        check("ab_done", 32'(o_done), 0);
        check("ab_settled", 32'(o_settled), 0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("held_accept_busy", 32'(o_busy), 1);
        wait_done(ticks);
        check("m2000_ticks", 32'(ticks), 7 + SETTLE_CNT);
        check("m2000_sp", 32'(o_setpoint), 2000);

        // Feedback stuck at 0 after ramping to 2068.
        send_cmd(2068);
        fb_track = 1'b0;
        fb_force = 12'd0;
`ifdef SEQ_SETTLE_TIMEOUT_EN
        begin
            int n = 0;
            ticks = 0;
            while (o_timeout !== 1'b1 && n < 400) begin
                if (o_sample_tick && o_busy) ticks++;
                @(negedge clk);
                n++;
            end
            check("to_pulse", 32'(o_timeout), 1);
            check("to_ticks", 32'(ticks), 9 + TIMEOUT_TICKS);
            check("to_busy", 32'(o_busy), 0);
            check("to_ready", 32'(cmd_if.cmd_ready), 1);
            check("to_settled", 32'(o_settled), 0);
            check("to_sp", 32'(o_setpoint), 2068);
            @(negedge clk);
            check("to_pulse_end", 32'(o_timeout), 0);
        end
`else
        begin
            bit all_busy = 1'b1;
            bit any_done = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (o_busy !== 1'b1) all_busy = 1'b0;
                if (o_done !== 1'b0 || o_timeout !== 1'b0) any_done = 1'b1;
            end
            check("hold_busy", 32'(all_busy), 1);
            check("hold_no_done", 32'(any_done), 0);
            check("hold_state", 32'(o_state), ST_SETTLE);
            i_abort = 1'b1;
            @(negedge clk);
            i_abort = 1'b0;
            check("settle_abort_busy", 32'(o_busy), 0);
            check("settle_abort_ready", 32'(cmd_if.cmd_ready), 1);
            check("settle_abort_settled", 32'(o_settled), 0);
            check("settle_abort_sp", 32'(o_setpoint), 2068);
        end
`endif
        fb_track = 1'b1;

        // Asynchronous reset in the middle of a ramp.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos   = 12'd2100;
        exp_q.push_back(12'd2076);
        exp_q.push_back(12'(HOME_POS));
        model_sp = HOME_POS;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        wait_tick();
        check("rr_sp1", 32'(o_setpoint), 2076);
        #3 rst_n = 1'b0;
        #1;
        check("rr_sp_home", 32'(o_setpoint), HOME_POS);
        check("rr_busy", 32'(o_busy), 0);
        check("rr_ready", 32'(cmd_if.cmd_ready), 1);
        check("rr_state", 32'(o_state), ST_IDLE);
        check("rr_done", 32'(o_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rr_still_idle", 32'(o_busy), 0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/servo_setpoint_sequencer.md
# servo_setpoint_sequencer

Motion sequencer in front of the servo PID loop. It accepts absolute target positions over a valid/ready handshake and slews the PID setpoint toward each target at a bounded rate per sample period. Once the setpoint arrives, it confirms that the feedback position has settled inside a tolerance window before it reports completion. Its `setpoint` output drives the PID's desired-position input; `position_fb` is the same 12-bit feedback that the PID consumes.

## Interface
- `SAMPLE_DIV`, 50000 — clk cycles per sample tick (1 kHz at 50 MHz); ≥2
- `STEP_MAX`, 8 — max setpoint change per tick, in position LSBs; 1..4095
- `SETTLE_TOL`, 4 — settled when |target − position_fb| ≤ this value
- `SETTLE_CNT`, 16 — consecutive in-tolerance ticks required; ≥1
- `TIMEOUT_TICKS`, 2000 — settle timeout in ticks (macro-gated)
- `HOME_POS`, 2048 — setpoint after reset (90°)
- `clk` in 1 — clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `cmd_valid` in 1 — target command valid
- `cmd_pos` in 12 — target position, unsigned
- `cmd_ready` out 1 — sequencer can accept a command
- `abort` in 1 — stop motion, freeze setpoint
- `position_fb` in 12 — measured position, unsigned
- `setpoint` out 12 — setpoint to the PID, registered
- `sample_tick` out 1 — one-cycle strobe every `SAMPLE_DIV` cycles
- `busy` out 1 — high in RAMP or SETTLE
- `done` out 1 — one-cycle pulse when a move settles
- `settled` out 1 — level: last move settled; cleared on the next accept
- `timeout` out 1 — one-cycle pulse on settle timeout; constant 0 without the macro

## Operation
- Tick counter:
  - Free-running from 0 to `SAMPLE_DIV`−1, then wraps to 0.
  - `sample_tick` is high during the cycle in which the counter equals `SAMPLE_DIV`−1.
  - The counter is never stopped or cleared by commands.
- States: IDLE, RAMP, SETTLE, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: latch `target`=`cmd_pos`, clear `settled`, go to RAMP.
  - `abort` has no effect in IDLE.
- RAMP:
  - On each tick, `diff` = `target` − `setpoint`, computed as 13-bit signed.
  - The setpoint moves by sign(`diff`)·min(|`diff`|, `STEP_MAX`).
  - If the updated setpoint equals `target`, go to SETTLE and clear the settle and timeout counters.
  - A zero-distance command reaches SETTLE on the first tick, with no setpoint change.
- SETTLE:
  - The setpoint is held at `target`.
  - On each tick, `position_fb` is compared with `target` using 13-bit signed math.
  - In tolerance: the settle count increments. Out of tolerance: the count resets to 0.
  - When the count reaches `SETTLE_CNT`, go to DONE.
- DONE:
  - Lasts one cycle: `done`=1, `settled` set to 1, then return to IDLE.
- Abort (in RAMP or SETTLE):
  - Next state is IDLE.
  - The setpoint is not updated on that edge, even if a tick coincides.
  - No `done`; `settled` stays 0.
- `cmd_valid` outside IDLE is not accepted. `cmd_pos` is ignored until `cmd_ready`=1.

## Timing
- Reset values:
  - `setpoint`=`HOME_POS`, state IDLE, `cmd_ready`=1.
  - `busy`, `done`, `settled`, `timeout`, `sample_tick` = 0.
  - Tick counter = 0.
- Command accepted at edge k: `busy`=1 and `cmd_ready`=0 from k+1.
- `setpoint` changes on the edge that ends a `sample_tick` cycle and is visible in the following cycle.
- Minimum move time, measured in ticks in RAMP:
  - ceil(|Δ|/`STEP_MAX`) ticks (at least 1);
  - then `SETTLE_CNT` ticks in SETTLE;
  - then 1 cycle in DONE.
- `done` rises on the edge after the tick that completes the settle count. `cmd_ready` returns 1 one cycle later.
- Asynchronous reset mid-move:
  - All state returns immediately to reset values, and the setpoint jumps to `HOME_POS`.
  - The move is lost without `done`.
- Abort asserted at edge k: `busy`=0 and `cmd_ready`=1 from k+1.

## Configuration
- `SEQ_SETTLE_TIMEOUT_EN` defined:
  - SETTLE counts every tick (in or out of tolerance).
  - When the count reaches `TIMEOUT_TICKS` before settling, the sequencer pulses `timeout` for one cycle and goes to IDLE. `settled` stays 0 and the setpoint is held at `target`.
  - If settle and timeout complete on the same tick, settle wins.
- `SEQ_SETTLE_TIMEOUT_EN` undefined:
  - No timeout counter; `timeout` is tied to 0.
  - SETTLE exits only by settling, abort or reset.

## Test plan
All scenarios use `SAMPLE_DIV`=4, `STEP_MAX`=8, `SETTLE_TOL`=4, `SETTLE_CNT`=3.
- Reset check: after reset release → `setpoint`=2048, `cmd_ready`=1, all flags 0; `sample_tick` pulses every 4 cycles.
- Command `cmd_pos`=2068, with `position_fb` tracking `setpoint`:
  - `setpoint` steps 2056 → 2064 → 2068 on three consecutive ticks;
  - after 3 more ticks, `done` pulses once and `settled`=1;
  - `cmd_ready`=1 the following cycle.
- Command `cmd_pos`=2040 (downward, 8 counts): `setpoint`=2040 after one tick, then settles → `done`.
- Out-of-tolerance recovery: during SETTLE to 2068, drive `position_fb`=2074 on the second tick (error 6) → settle count resets; `done` only after 3 further in-tolerance ticks.
- Abort on the same cycle as a RAMP tick, with `setpoint`=2056 heading to 2100 → `setpoint` stays 2056, IDLE next cycle, no `done`, `settled`=0. A command with `cmd_valid` held during RAMP is not accepted until IDLE.
- With `SEQ_SETTLE_TIMEOUT_EN` and `TIMEOUT_TICKS`=5: hold `position_fb`=0 after ramping to 2068 → `timeout` pulses 5 ticks into SETTLE, and `setpoint` stays 2068. Without the macro, `busy` stays 1 indefinitely.
